lcd_read_text: RTL and testbench

- Reverse direction of the LCD text path: reads one 16-character line of DDRAM back from the HD44780-style LCD in 4-bit mode.
- Sequence: write the Set-DDRAM-Address command (RS=0, RW=0), then issue LINE_LENGTH data reads (RS=1, RW=1), two nibbles each.
- Returns the line packed in the same byte order the text sender consumes.
- Self-timed: owns E/RW/RS and the bidirectional data nibble, and has its own delay counter.

---
 rtl/lcd_read_text_if.sv | 24 ++
 rtl/lcd_read_text.sv | 169 ++++++++++++++++
 tb/tb_lcd_read_text.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_read_text_if.sv
// Host-side request/response and LCD control strobes for the DDRAM line reader.
// The 4-bit data nibble is bidirectional and stays a plain port on the reader.
interface lcd_read_text_if #(
  parameter int LINE_LENGTH = 16
);
  logic                     readText;
  logic                     lineSel;
  logic [8*LINE_LENGTH:1]   lineData;
  logic                     readingDone;
  logic                     busy;
  logic                     LCD_RS;
  logic                     LCD_RW;
  logic                     LCD_E;

  modport slave (
    input  readText, lineSel,
    output lineData, readingDone, busy, LCD_RS, LCD_RW, LCD_E
  );

  modport master (
    output readText, lineSel,
    input  lineData, readingDone, busy, LCD_RS, LCD_RW, LCD_E
  );
endinterface

// File: rtl/lcd_read_text.sv
// Reads one line of DDRAM back from an HD44780-style LCD in 4-bit mode:
// Set-DDRAM-Address write, then LINE_LENGTH two-nibble data reads.
// Result is presented with char 0 in the top byte of lineData.
module lcd_read_text #(
  parameter int FREQ        = 50000000,
  parameter int LINE_LENGTH = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  lcd_read_text_if.slave    lcd,
  inout  wire  [3:0]        LCD_DB
);
  localparam int T1US  = FREQ / 1000000;
  localparam int T53US = 53 * T1US;
  localparam int IDX_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;

  localparam logic [20:0]      T1_LAST  = 21'(T1US - 1);
  localparam logic [20:0]      T53_LAST = 21'(T53US - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, ADDR_WAIT, RD_H, RD_L, RD_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_HOLD} phase_t;

  state_t                         state_q;
  phase_t                         ph_q;
  logic [20:0]                    cnt_q;
  logic [IDX_W-1:0]               idx_q;
  logic [LINE_LENGTH-1:0][7:0]    buf_q;
  logic [8*LINE_LENGTH:1]         line_q;
  logic                           done_q;
  logic                           busy_q;
  logic                           rs_q;
  logic                           rw_q;
  logic                           e_q;
  logic                           db_oe_q;
  logic [3:0]                     db_q;

  logic nib_last;
  logic wait_last;

  assign nib_last  = (cnt_q == T1_LAST);
  assign wait_last = (cnt_q == T53_LAST);

  // DB is only ever enabled while RW=0 (address write phases).
  assign LCD_DB = db_oe_q ? db_q : 4'bz;

  assign lcd.lineData    = line_q;
  assign lcd.readingDone = done_q;
  assign lcd.busy        = busy_q;
  assign lcd.LCD_RS      = rs_q;
  assign lcd.LCD_RW      = rw_q;
  assign lcd.LCD_E       = e_q;

  // Main sequencer: states, nibble phases, delay counter and all pin outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ph_q    <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      db_oe_q <= 1'b0;
      db_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lcd.readText) begin
            // lineSel is captured straight into the address-high nibble.
            state_q <= ADDR_H;
            ph_q    <= PH_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            db_oe_q <= 1'b1;
            db_q    <= lcd.lineSel ? 4'hC : 4'h8;
          end
        end

        ADDR_H, ADDR_L, RD_H, RD_L: begin
          if (!nib_last) begin
            cnt_q <= cnt_q + 21'd1;
          end else begin
            cnt_q <= '0;
            case (ph_q)
              PH_SETUP: begin
                ph_q <= PH_HIGH;
                e_q  <= 1'b1;
              end
              PH_HIGH: begin
                // Last cycle of E high: the LCD's read data is valid here.
                ph_q <= PH_HOLD;
                e_q  <= 1'b0;
                if (state_q == RD_H) buf_q[idx_q][7:4] <= LCD_DB;
                if (state_q == RD_L) buf_q[idx_q][3:0] <= LCD_DB;
              end
              default: begin
                ph_q <= PH_SETUP;
                if (state_q == ADDR_H) begin
                  state_q <= ADDR_L;
                  db_q    <= 4'h0;
                end else if (state_q == ADDR_L) begin
                  state_q <= ADDR_WAIT;
                  db_oe_q <= 1'b0;
                end else if (state_q == RD_H) begin
                  state_q <= RD_L;
                end else begin
                  state_q <= RD_WAIT;
                end
              end
            endcase
          end
        end

        ADDR_WAIT: begin
          if (wait_last) begin
            // RW rises long after DB was released on entry to this state.
            cnt_q   <= '0;
            state_q <= RD_H;
            ph_q    <= PH_SETUP;
            rs_q    <= 1'b1;
            rw_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 21'd1;
          end
        end

        RD_WAIT: begin
          if (wait_last) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rs_q    <= 1'b0;
              rw_q    <= 1'b0;
              for (int i = 0; i < LINE_LENGTH; i++)
                line_q[8*(LINE_LENGTH-1-i)+1 +: 8] <= buf_q[i];
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= RD_H;
              ph_q    <= PH_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + 21'd1;
          end
        end

        DONE: begin
          // readText is not looked at here; it is accepted from IDLE only.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_read_text.sv
// Bench for lcd_read_text: LCD DDRAM model, pulse timing monitor, queue scoreboard.
module tb_lcd_read_text;
  localparam int FREQ    = 4000000;
  localparam int L       = 16;
  localparam int T1      = FREQ / 1000000;
  localparam int T53     = 53 * T1;
  localparam int LAT_MIN = (L + 1) * (6 * T1 + T53);
  localparam int LAT_MAX = LAT_MIN + 2 * L + 4;

  typedef struct {
    logic [8*L:1] line;
    logic [7:0]   cmd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_read_text_if #(.LINE_LENGTH(L)) ifc ();
  wire [3:0] LCD_DB;

  lcd_read_text #(.FREQ(FREQ), .LINE_LENGTH(L)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .lcd     (ifc),
    .LCD_DB  (LCD_DB)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  exp_t exp_q[$];

  logic [8*L:1] LINE1;
  logic [8*L:1] LINE2;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- LCD model ----------------
  logic [7:0] ddram [128];
  logic [6:0] addr     = '0;
  bit         half     = 1'b0;
  bit         wr_half  = 1'b0;
  logic [3:0] cmd_hi   = '0;
  logic [7:0] last_cmd = 8'hFF;
  int         rd_nib   = 0;

  assign LCD_DB = (ifc.LCD_RW && ifc.LCD_E) ?
                  (half ? ddram[addr][3:0] : ddram[addr][7:4]) : 4'bz;

  always @(negedge ifc.LCD_E or negedge rst_n) begin
    if (!rst_n) begin
      half    = 1'b0;
      wr_half = 1'b0;
    end else if (!ifc.LCD_RW) begin
      if (!wr_half) begin
        cmd_hi  = LCD_DB;
        wr_half = 1'b1;
      end else begin
        wr_half  = 1'b0;
        last_cmd = {cmd_hi, LCD_DB};
        if (last_cmd[7]) begin
          addr = last_cmd[6:0];
          half = 1'b0;
        end
      end
    end else begin
      rd_nib = rd_nib + 1;
      if (!half) half = 1'b1;
      else begin
        half = 1'b0;
        addr = addr + 7'd1;
      end
    end
  end

  // ---------------- pulse timing monitor ----------------
  logic pe = 1'b0, prs = 1'b0, prw = 1'b0;
  int   stab = 0, hi = 0, t_viol = 0, t_pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pe <= 1'b0; prs <= 1'b0; prw <= 1'b0; stab <= 0; hi <= 0;
    end else begin
      pe  <= ifc.LCD_E;
      prs <= ifc.LCD_RS;
      prw <= ifc.LCD_RW;
      if (ifc.LCD_RS !== prs || ifc.LCD_RW !== prw) begin
        stab <= 1;
        if (ifc.LCD_E || pe) t_viol <= t_viol + 1;
      end else if (!ifc.LCD_E) begin
        stab <= stab + 1;
      end
      if (ifc.LCD_E && !pe) begin
        t_pulses <= t_pulses + 1;
        hi <= 1;
        if (stab < T1 || ifc.LCD_RS !== ifc.LCD_RW) t_viol <= t_viol + 1;
      end else if (ifc.LCD_E) begin
        hi <= hi + 1;
      end else if (pe && hi != T1) begin
        t_viol <= t_viol + 1;
      end
    end
  end

  // readingDone pulse counter
  always @(negedge clk) if (ifc.readingDone === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------- drivers ----------------
  // Called at a negedge; holds readText for exactly one rising edge.
  task automatic start_read(input bit sel, input logic [8*L:1] line, input bit push,
                            output int t0);
    exp_t e;
    if (push) begin
      e.line = line;
      e.cmd  = sel ? 8'hC0 : 8'h80;
      exp_q.push_back(e);
      exp_done++;
    end
    ifc.readText = 1'b1;
    ifc.lineSel  = sel;
    @(negedge clk);
    t0 = cyc;
    ifc.readText = 1'b0;
    ifc.lineSel  = ~sel;
  endtask

  task automatic wait_done(input int t0, input bit chk_hold, input logic [8*L:1] hold,
                           output bit seen, output int lat, output bit busy_ok,
                           output bit hold_ok);
    seen = 1'b0; lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int i = 0; i < LAT_MAX + 100 && !seen; i++) begin
      if (ifc.readingDone === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        if (ifc.busy !== 1'b1) busy_ok = 1'b0;
        if (chk_hold && ifc.lineData !== hold) hold_ok = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.LCD_E !== 1'b0) begin errors++; $display("FAIL reset_E got=%b exp=0", ifc.LCD_E); end
    checks++; if (ifc.LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_RW got=%b exp=0", ifc.LCD_RW); end
    checks++; if (ifc.LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_RS got=%b exp=0", ifc.LCD_RS); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    checks++; if (ifc.readingDone !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ifc.readingDone); end
    checks++; if (ifc.lineData !== '0) begin errors++; $display("FAIL reset_lineData got=%h exp=0", ifc.lineData); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_line1();
    int t0, lat; bit seen, bok, hok; exp_t e;
    start_read(1'b0, LINE1, 1'b1, t0);
    wait_done(t0, 1'b1, '0, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL l1_done_timeout got=none exp=pulse"); end
    checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL l1_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
    checks++; if (!bok) begin errors++; $display("FAIL l1_busy got=low exp=high throughout"); end
    checks++; if (!hok) begin errors++; $display("FAIL l1_lineData_early got=changed exp=0 until done"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL l1_line got=%h exp=%h", ifc.lineData, e.line); end
      checks++; if (last_cmd !== e.cmd) begin errors++; $display("FAIL l1_cmd got=%h exp=%h", last_cmd, e.cmd); end
    end
    checks++; if (ifc.lineData[128:121] !== 8'h48) begin errors++; $display("FAIL l1_char0 got=%h exp=48", ifc.lineData[128:121]); end
    checks++; if (ifc.lineData[8:1] !== 8'h20) begin errors++; $display("FAIL l1_char15 got=%h exp=20", ifc.lineData[8:1]); end
    @(negedge clk);
    checks++; if (ifc.readingDone !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL l1_after got=done%b busy%b exp=done0 busy0", ifc.readingDone, ifc.busy); end
    checks++; if (t_viol !== 0) begin errors++; $display("FAIL l1_timing got=%0d violations exp=0", t_viol); end
    checks++; if (t_pulses !== 2 + 2 * L) begin errors++; $display("FAIL l1_pulses got=%0d exp=%0d", t_pulses, 2 + 2 * L); end
  endtask

  task automatic test_line2();
    int t0, lat; bit seen, bok, hok; exp_t e;
    start_read(1'b1, LINE2, 1'b1, t0);
    wait_done(t0, 1'b1, LINE1, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL l2_done_timeout got=none exp=pulse"); end
    checks++; if (!hok) begin errors++; $display("FAIL l2_hold got=changed exp=line1 until done"); end
    checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL l2_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL l2_line got=%h exp=%h", ifc.lineData, e.line); end
      checks++; if (last_cmd !== e.cmd) begin errors++; $display("FAIL l2_cmd got=%h exp=%h", last_cmd, e.cmd); end
    end
    @(negedge clk);
  endtask

  task automatic test_retrigger();
    int t0, lat, base; bit seen, bok, hok; exp_t e;
    base = rd_nib;
    start_read(1'b0, LINE1, 1'b1, t0);
    for (int i = 0; i < LAT_MAX && rd_nib < base + 6; i++) @(negedge clk);
    checks++; if (rd_nib < base + 6) begin errors++; $display("FAIL rt_char3_timeout got=%0d exp=%0d nibbles", rd_nib - base, 6); end
    ifc.readText = 1'b1; ifc.lineSel = 1'b1;
    @(negedge clk);
    ifc.readText = 1'b0; ifc.lineSel = 1'b0;
    wait_done(t0, 1'b1, LINE2, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL rt_done_timeout got=none exp=pulse"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL rt_line got=%h exp=%h", ifc.lineData, e.line); end
      checks++; if (last_cmd !== e.cmd) begin errors++; $display("FAIL rt_cmd got=%h exp=%h", last_cmd, e.cmd); end
    end
    // readText in the DONE cycle must be ignored
    ifc.readText = 1'b1; ifc.lineSel = 1'b1;
    @(negedge clk);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rt_done_cycle_accept got=busy%b exp=busy0", ifc.busy); end
    // held into the following IDLE cycle: accepted
    start_read(1'b1, LINE2, 1'b1, t0);
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL rt_next_accept got=busy%b exp=busy1", ifc.busy); end
    wait_done(t0, 1'b1, LINE1, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL rt2_done_timeout got=none exp=pulse"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL rt2_line got=%h exp=%h", ifc.lineData, e.line); end
      checks++; if (last_cmd !== e.cmd) begin errors++; $display("FAIL rt2_cmd got=%h exp=%h", last_cmd, e.cmd); end
    end
    @(negedge clk);
    checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL rt_done_count got=%0d exp=%0d", done_cnt, exp_done); end
  endtask

  task automatic test_reset_mid();
    int t0, lat, base; bit seen, bok, hok; exp_t e;
    base = rd_nib;
    start_read(1'b0, LINE1, 1'b0, t0);
    for (int i = 0; i < LAT_MAX && rd_nib < base + 11; i++) @(negedge clk);
    checks++; if (rd_nib < base + 11) begin errors++; $display("FAIL rm_char5_timeout got=%0d exp=%0d nibbles", rd_nib - base, 11); end
    repeat (2 * T1 + 1) @(negedge clk);
    checks++; if (ifc.LCD_E !== 1'b1) begin errors++; $display("FAIL rm_pre_E got=%b exp=1", ifc.LCD_E); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ifc.LCD_E, ifc.LCD_RW, ifc.LCD_RS, ifc.busy} !== 4'b0) begin errors++; $display("FAIL rm_pins got=E%b RW%b RS%b busy%b exp=0000", ifc.LCD_E, ifc.LCD_RW, ifc.LCD_RS, ifc.busy); end
    checks++; if (ifc.lineData !== '0) begin errors++; $display("FAIL rm_lineData got=%h exp=0", ifc.lineData); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ifc.busy !== 1'b0 || ifc.readingDone !== 1'b0) begin errors++; $display("FAIL rm_idle got=busy%b done%b exp=00", ifc.busy, ifc.readingDone); end
    start_read(1'b0, LINE1, 1'b1, t0);
    wait_done(t0, 1'b1, '0, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL rm_done_timeout got=none exp=pulse"); end
    checks++; if (!hok) begin errors++; $display("FAIL rm_hold got=changed exp=0 until done"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL rm_line got=%h exp=%h", ifc.lineData, e.line); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, lat; bit seen, bok, hok; exp_t e;
    start_read(1'b0, LINE1, 1'b1, t0);
    wait_done(t0, 1'b1, LINE1, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL bb1_done_timeout got=none exp=pulse"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL bb1_line got=%h exp=%h", ifc.lineData, e.line); end
    end
    @(negedge clk);
    start_read(1'b1, LINE2, 1'b1, t0);
    wait_done(t0, 1'b1, LINE1, seen, lat, bok, hok);
    checks++; if (!seen) begin errors++; $display("FAIL bb2_done_timeout got=none exp=pulse"); end
    checks++; if (!hok) begin errors++; $display("FAIL bb2_hold got=changed exp=line1 until done"); end
    if (seen) begin
      e = exp_q.pop_front();
      checks++; if (ifc.lineData !== e.line) begin errors++; $display("FAIL bb2_line got=%h exp=%h", ifc.lineData, e.line); end
      checks++; if (last_cmd !== e.cmd) begin errors++; $display("FAIL bb2_cmd got=%h exp=%h", last_cmd, e.cmd); end
    end
    @(negedge clk);
  endtask

  initial begin
    LINE1 = "HELLO WORLD     ";
    LINE2 = 128'h303132333435363738393A3B3C3D3E3F;
    for (int i = 0; i < 128; i++) ddram[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < L; i++) begin
      ddram[i]        = LINE1[8*(L-1-i)+1 +: 8];
      ddram[8'h40 + i] = LINE2[8*(L-1-i)+1 +: 8];
    end
    ifc.readText = 1'b0;
    ifc.lineSel  = 1'b0;

    test_reset();
    test_line1();
    test_line2();
    test_retrigger();
    test_reset_mid();
    test_back_to_back();

    checks++; if (t_viol !== 0) begin errors++; $display("FAIL timing_total got=%0d violations exp=0", t_viol); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL done_total got=%0d exp=%0d", done_cnt, exp_done); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
